// File: rtl/mem_pkg.sv
// Shared types and sizing for the memory stage: FSM states, datapath widths, watchdog limit.
package mem_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned VEC_W       = 128;
   localparam int unsigned BEATS_VEC   = 4;
   localparam int unsigned TIMEOUT_MAX = 255;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_e;

   // Byte address of a beat; wraps modulo 2^32 by construction.
   function automatic logic [WORD_W-1:0] beat_addr(input logic [WORD_W-1:0] base,
                                                   input logic [1:0]        beat);
      return base + {{(WORD_W-4){1'b0}}, beat, 2'b00};
   endfunction

endpackage

// File: rtl/vec_lane_assembler.sv
// 128-bit lane register: preloaded with store data (or zero for loads), one 32-bit lane
// written per acked load beat, one lane read out per store beat.
module vec_lane_assembler
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_init_en,
   input  logic [VEC_W-1:0]  i_init,
   input  logic              i_wr_en,
   input  logic [1:0]        i_lane,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [VEC_W-1:0]  o_lanes_next,
   output logic [WORD_W-1:0] o_rdata
);

   logic [VEC_W-1:0] r_lanes;

   // Exposes the register with the current beat already merged so the final beat can be
   // written back in the same edge that retires it.
   always_comb begin
      o_lanes_next = r_lanes;
      if (i_wr_en) begin
         o_lanes_next[{i_lane, 5'd0} +: WORD_W] = i_wdata;
      end
   end

   assign o_rdata = r_lanes[{i_lane, 5'd0} +: WORD_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lanes <= '0;
      end else if (i_init_en) begin
         r_lanes <= i_init;
      end else begin
         r_lanes <= o_lanes_next;
      end
   end

endmodule

// File: rtl/memory_module.sv
// Pipeline memory stage: ALU pass-through or 1/4-beat 32-bit memory access with stall.
// Optional access watchdog and sticky mem_err port enabled by defining MEM_TIMEOUT_EN.
module memory_module
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              MemRd,
   input  logic              MemWr,
   input  logic              RegWr_in,
   input  logic              VF_in,
   input  logic [3:0]        R_V_dest_in,
   input  logic [WORD_W-1:0] ALURES,
   input  logic [VEC_W-1:0]  ALURES1,
   input  logic [VEC_W-1:0]  R3_V3,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              valid_out,
   output logic              RegWr_out,
   output logic              VF,
   output logic [3:0]        R_V_dest,
   output logic [VEC_W-1:0]  ResRV
`ifdef MEM_TIMEOUT_EN
   ,
   output logic              mem_err
`endif
);

   state_e            r_state, w_state_next;
   logic [1:0]        r_beat;
   logic [WORD_W-1:0] r_base;
   logic              r_is_vec, r_is_store, r_regwr, r_vf_op;
   logic [3:0]        r_dest_op;
   logic              r_valid_out, r_regwr_out, r_vf;
   logic [3:0]        r_dest;
   logic [VEC_W-1:0]  r_resrv;

   logic              w_access, w_accept, w_start, w_alu, w_last;
   logic              w_beat_ack, w_done_ok, w_timeout;
   logic [VEC_W-1:0]  w_lanes_next;
   logic [WORD_W-1:0] w_lane_rdata;

   assign w_access   = (r_state == ACCESS);
   // DONE accepts new work exactly like IDLE, giving back-to-back operations.
   assign w_accept   = rst && valid_in && !w_access;
   assign w_start    = w_accept && (MemRd || MemWr);
   assign w_alu      = w_accept && !(MemRd || MemWr);
   assign w_beat_ack = w_access && mem_ack;
   assign w_last     = r_is_vec ? (r_beat == 2'(BEATS_VEC - 1)) : (r_beat == 2'd0);
   assign w_done_ok  = w_beat_ack && w_last;

`ifdef MEM_TIMEOUT_EN
   logic [7:0] r_wdog;
   logic       r_mem_err;

   assign w_timeout = w_access && !mem_ack && (r_wdog == 8'(TIMEOUT_MAX - 1));
   assign mem_err   = r_mem_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wdog    <= '0;
         r_mem_err <= 1'b0;
      end else begin
         if (!w_access || mem_ack) begin
            r_wdog <= '0;
         end else begin
            r_wdog <= r_wdog + 8'd1;
         end
         if (w_timeout) begin
            r_mem_err <= 1'b1;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE, DONE: w_state_next = w_start ? ACCESS : IDLE;
         ACCESS:     if (w_done_ok || w_timeout) w_state_next = DONE;
         default:    w_state_next = IDLE;
      endcase
   end

   assign stall     = w_access || w_start;
   assign mem_req   = w_access;
   assign mem_we    = w_access && r_is_store;
   assign mem_addr  = w_access ? beat_addr(r_base, r_beat) : '0;
   assign mem_wdata = (w_access && r_is_store) ? w_lane_rdata : '0;

   assign valid_out = r_valid_out;
   assign RegWr_out = r_regwr_out;
   assign VF        = r_vf;
   assign R_V_dest  = r_dest;
   assign ResRV     = r_resrv;

   vec_lane_assembler u_lanes (
      .clk          (clk),
      .rst          (rst),
      .i_init_en    (w_start),
      .i_init       ((MemWr && !MemRd) ? R3_V3 : '0),
      .i_wr_en      (w_beat_ack && !r_is_store),
      .i_lane       (r_beat),
      .i_wdata      (mem_rdata),
      .o_lanes_next (w_lanes_next),
      .o_rdata      (w_lane_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_beat      <= '0;
         r_base      <= '0;
         r_is_vec    <= 1'b0;
         r_is_store  <= 1'b0;
         r_regwr     <= 1'b0;
         r_vf_op     <= 1'b0;
         r_dest_op   <= '0;
         r_valid_out <= 1'b0;
         r_regwr_out <= 1'b0;
         r_vf        <= 1'b0;
         r_dest      <= '0;
         r_resrv     <= '0;
      end else begin
         r_state     <= w_state_next;
         r_valid_out <= 1'b0;
         if (w_alu) begin
            r_valid_out <= 1'b1;
            r_regwr_out <= RegWr_in;
            r_vf        <= VF_in;
            r_dest      <= R_V_dest_in;
            r_resrv     <= ALURES1;
         end
         if (w_start) begin
            r_beat     <= '0;
            r_base     <= ALURES;
            r_is_vec   <= VF_in;
            r_is_store <= MemWr && !MemRd;
            r_regwr    <= RegWr_in;
            r_vf_op    <= VF_in;
            r_dest_op  <= R_V_dest_in;
         end
         if (w_beat_ack) begin
            r_beat <= r_beat + 2'd1;
         end
         if (w_done_ok) begin
            r_valid_out <= 1'b1;
            r_regwr_out <= r_regwr && !r_is_store;
            r_vf        <= r_vf_op;
            r_dest      <= r_dest_op;
            if (!r_is_store) begin
               r_resrv <= w_lanes_next;
            end
         end
         if (w_timeout) begin
            r_valid_out <= 1'b1;
            r_regwr_out <= 1'b0;
            r_vf        <= r_vf_op;
            r_dest      <= r_dest_op;
         end
      end
   end

endmodule

// File: doc/memory_module.md
MEMORY_MODULE -- requirements
Module: memory_module

Interface
REQ-001 SHALL have the following ports, clock and reset first:
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-low reset.
  valid_in  in  1  execute-stage result valid this cycle.
  MemRd  in  1  load operation.
  MemWr  in  1  store operation.
  RegWr_in  in  1  destination register write enable.
  VF_in  in  1  vector operation flag.
  R_V_dest_in  in  4  destination register index.
  ALURES  in  32  scalar result; byte address for loads/stores.
  ALURES1  in  128  full (vector or zero-extended scalar) ALU result.
  R3_V3  in  128  store data.
  stall  out  1  upstream hold; execute stage freezes while high.
  mem_req  out  1  memory beat request.
  mem_we  out  1  write beat.
  mem_addr  out  32  beat address.
  mem_wdata  out  32  beat write data.
  mem_ack  in  1  beat complete; mem_rdata valid in the same cycle.
  mem_rdata  in  32  beat read data.
  valid_out  out  1  forwarded/writeback result valid.
  RegWr_out  out  1  registered write enable.
  VF  out  1  vector flag of the result, feeds the forwarding unit.
  R_V_dest  out  4  result destination, feeds the forwarding unit.
  ResRV  out  128  result value, feeds the forwarding unit and the register files.
  mem_err  out  1  sticky timeout error, present only with MEM_TIMEOUT_EN.

Function
REQ-002 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-003 In IDLE with valid_in=1 and MemRd=MemWr=0: SHALL register ALURES1, VF_in, R_V_dest_in and RegWr_in into the outputs next edge; valid_out=1; latency 1; stall=0.
REQ-004 In IDLE with valid_in=1 and (MemRd or MemWr): SHALL latch the operands, go to ACCESS, and drive stall=1 combinationally in that same cycle; stall stays 1 until DONE.
REQ-005 Beat count SHALL be 4 when VF_in=1 and 1 otherwise; beat i uses mem_addr = ALURES + 4*i (modulo 2^32; wrap past 0xFFFFFFFC is legal) and data lane [32i+31:32i].
REQ-006 In ACCESS: mem_req=1 and mem_we=MemWr, with address and data held stable until mem_ack; on mem_ack the beat counter SHALL advance, and mem_req may stay high for the next beat in the following cycle.
REQ-007 On load, each acked beat SHALL write mem_rdata into lane i of ResRV; on a scalar load, lanes 1-3 SHALL be 0.
REQ-008 After the last ack: go to DONE; in DONE valid_out=1 for exactly 1 cycle and stall=0; then go to IDLE. A new valid_in accepted in DONE SHALL be handled as from IDLE (back-to-back ops).
REQ-009 A store SHALL produce valid_out=1 with RegWr_out=0 and ResRV unchanged.
REQ-010 MemRd and MemWr both high SHALL be treated as a load.
REQ-011 valid_out SHALL be 0 in every cycle not covered by REQ-003/REQ-008; VF, R_V_dest and ResRV hold their last values.
REQ-012 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-013 rst=0 SHALL asynchronously force IDLE, beat counter 0, mem_req=0, mem_we=0, stall=0, valid_out=0, RegWr_out=0, VF=0, R_V_dest=0, ResRV=0, mem_addr=0, mem_wdata=0, mem_err=0.
REQ-014 Reset in ACCESS SHALL abort the access with no partial writeback; mem_req drops in the same cycle.

Configuration
REQ-015 With MEM_TIMEOUT_EN defined: an 8-bit watchdog counts ACCESS cycles without ack; at 255 it SHALL abort to DONE with valid_out=1, RegWr_out=0, and mem_err set sticky until reset.
REQ-016 Without MEM_TIMEOUT_EN: no watchdog, no mem_err port, and ACCESS waits indefinitely.

Structure
REQ-017 Package mem_pkg SHALL hold the state enum, WORD_W=32, VEC_W=128, BEATS_VEC=4 and TIMEOUT_MAX=255.
REQ-018 One sub-module, vec_lane_assembler, SHALL hold the lane register and the lane-select write/read logic.

Verification
REQ-019 ALU op valid_in=1, ALURES1=0x...DEADBEEF, R_V_dest_in=5 -> next cycle valid_out=1, ResRV=ALURES1, R_V_dest=5, stall=0.
REQ-020 Vector load at ALURES=0x100, ack every cycle, rdata 0x11, 0x22, 0x33, 0x44 -> addresses 0x100/104/108/10C; ResRV=0x00000044_00000033_00000022_00000011; valid_out 1 cycle after the 4th ack.
REQ-021 Scalar store at 0x20, R3_V3[31:0]=0xCAFE, ack delayed 3 cycles -> mem_req, mem_we, mem_addr and mem_wdata held stable for 3 cycles; stall=1 throughout; valid_out=1 with RegWr_out=0.
REQ-022 Vector load at 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-023 rst asserted after the 2nd ack of a vector load -> mem_req=0 immediately, valid_out never asserts, state IDLE.
REQ-024 MEM_TIMEOUT_EN defined, mem_ack never asserted -> abort after 255 cycles, mem_err=1, valid_out pulses with RegWr_out=0.
